seq_divider_8bit: RTL and testbench

//  Multi-cycle unsigned restoring divider: the inverse datapath to the ripple-carry adder.

---
 rtl/cpu_defs_pkg.sv | 12 +
 rtl/full_adder.sv | 13 +
 rtl/subtractor_nbit.sv | 27 ++
 rtl/seq_divider_8bit.sv | 122 ++++++++++++
 tb/tb_seq_divider_8bit.sv | 209 ++++++++++++++++++++
 5 files changed

// File: rtl/cpu_defs_pkg.sv
// Shared CPU definitions: default datapath width and divider state encodings.
package cpu_defs;

   localparam int unsigned CPU_WIDTH = 8;

   typedef enum logic [1:0] {
      DIV_IDLE = 2'd0,
      DIV_CALC = 2'd1,
      DIV_DONE = 2'd2
   } div_state_e;

endpackage

// File: rtl/full_adder.sv
// One-bit full adder cell used to build ripple chains.
module full_adder (
   input  logic a_i,
   input  logic b_i,
   input  logic c_i,
   output logic s_o,
   output logic c_o
);

   assign s_o = a_i ^ b_i ^ c_i;
   assign c_o = (a_i & b_i) | (a_i & c_i) | (b_i & c_i);

endmodule

// File: rtl/subtractor_nbit.sv
// Ripple-borrow subtractor: a - b as a + ~b + 1; final carry high means no borrow.
module subtractor_nbit #(
   parameter int unsigned WIDTH = 9
) (
   input  logic [WIDTH-1:0] a_i,
   input  logic [WIDTH-1:0] b_i,
   output logic [WIDTH-1:0] diff_o,
   output logic             no_borrow_o
);

   logic [WIDTH:0] carry;

   assign carry[0] = 1'b1;

   for (genvar i = 0; i < WIDTH; i++) begin : g_cell
      full_adder u_fa (
         .a_i (a_i[i]),
         .b_i (~b_i[i]),
         .c_i (carry[i]),
         .s_o (diff_o[i]),
         .c_o (carry[i+1])
      );
   end

   assign no_borrow_o = carry[WIDTH];

endmodule

// File: rtl/seq_divider_8bit.sv
// Multi-cycle unsigned restoring divider, one quotient bit per clock,
// with a start/busy/done handshake and divide-by-zero flag.
module seq_divider_8bit
   import cpu_defs::*;
#(
   parameter int unsigned WIDTH = CPU_WIDTH
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] dividend,
   input  logic [WIDTH-1:0] divisor,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] quotient,
   output logic [WIDTH-1:0] remainder,
   output logic             div_by_zero
);

   localparam int unsigned CntW = $clog2(WIDTH);

   div_state_e       state_q, state_d;
   logic [CntW-1:0]  cnt_q, cnt_d;
   logic [WIDTH-1:0] q_q, q_d, d_q, d_d;
   logic [WIDTH-1:0] quo_q, quo_d, rem_q, rem_d;
   logic [WIDTH:0]   r_q, r_d;
   logic             busy_q, done_q, dbz_q, dbz_d;

   logic [WIDTH:0]   trial, diff, r_next;
   logic [WIDTH-1:0] q_shift;
   logic             no_borrow;

   // Shift the next dividend bit into the partial remainder (modulo 2^(WIDTH+1)).
   assign trial = (r_q << 1) | {{WIDTH{1'b0}}, q_q[WIDTH-1]};

   subtractor_nbit #(
      .WIDTH (WIDTH + 1)
   ) u_sub (
      .a_i         (trial),
      .b_i         ({1'b0, d_q}),
      .diff_o      (diff),
      .no_borrow_o (no_borrow)
   );

   assign r_next  = no_borrow ? diff : trial;
   assign q_shift = {q_q[WIDTH-2:0], no_borrow};

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      q_d     = q_q;
      r_d     = r_q;
      d_d     = d_q;
      quo_d   = quo_q;
      rem_d   = rem_q;
      dbz_d   = dbz_q;
      case (state_q)
         DIV_IDLE: begin
            if (start) begin
               d_d   = divisor;
               q_d   = dividend;
               r_d   = '0;
               cnt_d = CntW'(WIDTH - 1);
               dbz_d = 1'b0;
               if (divisor == '0) begin
                  state_d = DIV_DONE;
                  quo_d   = '1;
                  rem_d   = dividend;
                  dbz_d   = 1'b1;
               end else begin
                  state_d = DIV_CALC;
               end
            end
         end
         DIV_CALC: begin
            q_d   = q_shift;
            r_d   = r_next;
            cnt_d = cnt_q - CntW'(1);
            if (cnt_q == '0) begin
               state_d = DIV_DONE;
               quo_d   = q_shift;
               rem_d   = r_next[WIDTH-1:0];
            end
         end
         DIV_DONE: state_d = DIV_IDLE;
         default:  state_d = DIV_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= DIV_IDLE;
         cnt_q   <= '0;
         q_q     <= '0;
         r_q     <= '0;
         d_q     <= '0;
         quo_q   <= '0;
         rem_q   <= '0;
         dbz_q   <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         q_q     <= q_d;
         r_q     <= r_d;
         d_q     <= d_d;
         quo_q   <= quo_d;
         rem_q   <= rem_d;
         dbz_q   <= dbz_d;
         busy_q  <= (state_d == DIV_CALC);
         done_q  <= (state_d == DIV_DONE);
      end
   end

   assign busy        = busy_q;
   assign done        = done_q;
   assign quotient    = quo_q;
   assign remainder   = rem_q;
   assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_seq_divider_8bit.sv
// Bench for seq_divider_8bit: transaction-level model compared every cycle,
// plus directed vectors with literal expected results and latencies.
module tb_seq_divider_8bit;

   localparam int unsigned W = 8;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic         start = 1'b0;
   logic [W-1:0] dividend = '0;
   logic [W-1:0] divisor = '0;
   logic         busy, done, div_by_zero;
   logic [W-1:0] quotient, remainder;

   int n_run  = 0;
   int n_fail = 0;
   bit chk_en = 1'b0;

   seq_divider_8bit #(
      .WIDTH (W)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .start       (start),
      .dividend    (dividend),
      .divisor     (divisor),
      .busy        (busy),
      .done        (done),
      .quotient    (quotient),
      .remainder   (remainder),
      .div_by_zero (div_by_zero)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_run++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Model: an accepted operation finishes WIDTH+1 cycles later (1 for divide by zero)
   // with a/b and a%b; results hold until the next done.
   logic         m_idle = 1'b1;
   logic         m_busy = 1'b0;
   logic         m_done = 1'b0;
   logic         m_dbz  = 1'b0;
   logic [W-1:0] m_q = '0, m_r = '0, p_q = '0, p_r = '0;
   int           m_left = 0;

   always @(posedge clk) begin
      if (rst) begin
         m_idle <= 1'b1;
         m_busy <= 1'b0;
         m_done <= 1'b0;
         m_dbz  <= 1'b0;
         m_q    <= '0;
         m_r    <= '0;
         m_left <= 0;
      end else if (m_idle && start) begin
         m_idle <= 1'b0;
         if (divisor == 0) begin
            m_done <= 1'b1;
            m_dbz  <= 1'b1;
            m_q    <= '1;
            m_r    <= dividend;
         end else begin
            m_busy <= 1'b1;
            m_dbz  <= 1'b0;
            m_left <= W;
            p_q    <= dividend / divisor;
            p_r    <= dividend % divisor;
         end
      end else if (m_busy) begin
         m_left <= m_left - 1;
         if (m_left == 1) begin
            m_busy <= 1'b0;
            m_done <= 1'b1;
            m_q    <= p_q;
            m_r    <= p_r;
         end
      end else if (m_done) begin
         m_done <= 1'b0;
         m_idle <= 1'b1;
      end
   end

   always @(negedge clk) begin
      if (chk_en) begin
         check("cyc busy", busy, m_busy);
         check("cyc done", done, m_done);
         check("cyc quotient", quotient, m_q);
         check("cyc remainder", remainder, m_r);
         check("cyc div_by_zero", div_by_zero, m_dbz);
      end
   end

   task automatic step();
      @(posedge clk);
      #2;
   endtask

   // Launch one division, scramble the operand inputs, then wait (bounded) for done.
   task automatic run_div(input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic [W-1:0] eq, input logic [W-1:0] er,
                          input logic edbz, input int elat, input string tag);
      int n;
      dividend = a;
      divisor  = b;
      start    = 1'b1;
      step();
      start    = 1'b0;
      dividend = W'($urandom);
      divisor  = W'($urandom);
      n = 1;
      while (!done && n < 20) begin
         step();
         n++;
      end
      check({tag, " latency"}, n, elat);
      check({tag, " quotient"}, quotient, eq);
      check({tag, " remainder"}, remainder, er);
      check({tag, " div_by_zero"}, div_by_zero, edbz);
      step();
   endtask

   initial begin
      int n;
      int extra_done;
      logic [W-1:0] a, b;

      step();
      step();
      chk_en = 1'b1;
      check("reset busy", busy, 0);
      check("reset done", done, 0);
      check("reset quotient", quotient, 0);
      check("reset remainder", remainder, 0);
      check("reset dbz", div_by_zero, 0);
      rst = 1'b0;
      step();

      run_div(8'd100, 8'd7, 8'd14, 8'd2, 1'b0, 9, "100/7");
      run_div(8'd255, 8'd1, 8'd255, 8'd0, 1'b0, 9, "255/1");
      run_div(8'd5, 8'd10, 8'd0, 8'd5, 1'b0, 9, "5/10");
      run_div(8'd37, 8'd0, 8'hFF, 8'd37, 1'b1, 1, "37/0");
      run_div(8'd0, 8'd9, 8'd0, 8'd0, 1'b0, 9, "0/9");

      // 200/3 with a second start and changed operands in cycle 4.
      dividend = 8'd200;
      divisor  = 8'd3;
      start    = 1'b1;
      step();
      start = 1'b0;
      step();
      step();
      step();
      start    = 1'b1;
      dividend = 8'd50;
      divisor  = 8'd5;
      step();
      start = 1'b0;
      n = 5;
      while (!done && n < 20) begin
         step();
         n++;
      end
      check("200/3 latency", n, 9);
      check("200/3 quotient", quotient, 66);
      check("200/3 remainder", remainder, 2);
      extra_done = 0;
      repeat (12) begin
         step();
         if (done) extra_done++;
      end
      check("200/3 no second done", extra_done, 0);

      // Reset in cycle 5 of 100/7.
      dividend = 8'd100;
      divisor  = 8'd7;
      start    = 1'b1;
      step();
      start = 1'b0;
      repeat (4) step();
      rst = 1'b1;
      step();
      rst = 1'b0;
      check("mid rst busy", busy, 0);
      check("mid rst done", done, 0);
      check("mid rst quotient", quotient, 0);
      check("mid rst remainder", remainder, 0);
      run_div(8'd9, 8'd4, 8'd2, 8'd1, 1'b0, 9, "9/4");

      repeat (300) begin
         a = W'($urandom_range(0, 255));
         b = ($urandom_range(0, 15) == 0) ? '0 : W'($urandom_range(1, 255));
         repeat ($urandom_range(0, 2)) step();
         if (b == 0) run_div(a, b, 8'hFF, a, 1'b1, 1, "rand");
         else        run_div(a, b, a / b, a % b, 1'b0, 9, "rand");
      end

      step();
      $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
      $finish;
   end

endmodule
